// File: rtl/display_pkg.sv
// Shared display types: mode encoding, blank nibble and active-low gfedcba glyphs.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_AB = 2'd0,
    MODE_C  = 2'd1,
    MODE_D  = 2'd2
  } mode_t;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hF:    glyph = GLYPH_BLANK;
      default: glyph = GLYPH_DASH;
    endcase
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// 2-flop synchronizer followed by a stable-count debouncer for one switch.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_async,
  output logic sw_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      sw_db <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], sw_async};
      // any cycle agreeing with the accepted value restarts the stability window
      if (sync[1] == sw_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw_db <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// 8-digit multiplexed 7-segment scanner with debounced mode switches and
// frame-aligned snapshot of the digit sources.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV        = 16384,
  parameter int BLANK_CYCLES    = 1024,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw_left,
  input  logic        sw_right,
  input  logic [15:0] digits_A,
  input  logic [15:0] digits_B,
  input  logic [15:0] digits_C,
  input  logic [15:0] digits_D,
  output logic [6:0]  segments,
  output logic [7:0]  anodes,
  output logic [1:0]  mode
);

  localparam int NUM_SW = 2;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {S_BLANK, S_ON} scan_state_t;

  logic [NUM_SW-1:0] sw_async, sw_db;
  assign sw_async = {sw_right, sw_left};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_async (sw_async[i]),
      .sw_db    (sw_db[i])
    );
  end

  mode_t             mode_req, mode_q, mode_nxt;
  scan_state_t       state_q, state_nxt;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic [2:0]        idx_q, idx_nxt;
  logic [3:0][15:0]  snap_q, snap_nxt;
  logic              load_pend;
  logic              frame_load;
  logic [15:0]       src;
  logic [3:0]        nib;
  logic [7:0]        anodes_nxt;
  logic [6:0]        segments_nxt;

  // right switch has priority, so MODE 3 can never be requested
  assign mode_req = sw_db[1] ? MODE_D : (sw_db[0] ? MODE_C : MODE_AB);
  assign mode     = mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      snap_q    <= '1;
      mode_q    <= MODE_AB;
      load_pend <= 1'b1;
      anodes    <= 8'hFF;
      segments  <= GLYPH_BLANK;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      idx_q     <= idx_nxt;
      snap_q    <= snap_nxt;
      mode_q    <= mode_nxt;
      load_pend <= 1'b0;
      anodes    <= anodes_nxt;
      segments  <= segments_nxt;
    end
  end

  // Outputs are decoded from next-state values so the registered pins line up
  // with the registered scan position.
  always_comb begin
    cnt_nxt      = cnt_q + 1'b1;
    idx_nxt      = idx_q;
    state_nxt    = state_q;
    snap_nxt     = snap_q;
    mode_nxt     = mode_q;
    src          = snap_q[0];
    nib          = BLANK_NIBBLE;
    anodes_nxt   = 8'hFF;
    segments_nxt = GLYPH_BLANK;

    if (cnt_q == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = idx_q + 3'd1;
    end

    frame_load = load_pend || (cnt_q == CNT_LAST && idx_q == 3'd7);
    if (frame_load) begin
      snap_nxt = {digits_D, digits_C, digits_B, digits_A};
      mode_nxt = mode_req;
    end

    case (state_q)
      S_BLANK: if (cnt_nxt == CNT_BLANK) state_nxt = S_ON;
      S_ON:    if (cnt_q == CNT_LAST)    state_nxt = S_BLANK;
      default: state_nxt = S_BLANK;
    endcase

    if (!idx_nxt[2]) begin
      case (mode_nxt)
        MODE_C:  src = snap_nxt[2];
        MODE_D:  src = snap_nxt[3];
        default: src = snap_nxt[0];
      endcase
      nib = src[{idx_nxt[1:0], 2'b00} +: 4];
    end else if (mode_nxt == MODE_AB) begin
      src = snap_nxt[1];
      nib = src[{idx_nxt[1:0], 2'b00} +: 4];
    end

    if (state_nxt == S_ON) begin
      segments_nxt = glyph(nib);
      if (nib != BLANK_NIBBLE) anodes_nxt = ~(8'd1 << idx_nxt);
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: a frame/slot-level model predicts every output cycle,
// a monitor pops and compares each cycle mid-period.
module tb_display_scan_controller;

  localparam int SD = 8, BC = 2, DC = 4;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0, rst_n = 1'b0, sw_left = 1'b0, sw_right = 1'b0;
  logic [15:0] digits_A = '0, digits_B = '0, digits_C = '0, digits_D = '0;
  logic [6:0]  segments;
  logic [7:0]  anodes;
  logic [1:0]  mode;

  always #5 clk = ~clk;

  display_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .sw_left(sw_left), .sw_right(sw_right),
    .digits_A(digits_A), .digits_B(digits_B), .digits_C(digits_C), .digits_D(digits_D),
    .segments(segments), .anodes(anodes), .mode(mode)
  );

  typedef struct packed { logic [7:0] an; logic [6:0] seg; logic [1:0] md; } exp_t;

  exp_t        exp_q[$];
  logic        hl[$], hr[$], dbl[$], dbr[$];
  logic [15:0] ha[$], hb[$], hc[$], hd[$];
  logic        cur_l = 1'b0, cur_r = 1'b0;
  logic [15:0] cur_a = '0, cur_b = '0, cur_c = '0, cur_d = '0;
  int          n_cmp = 0, n_bad = 0, tick = 0;
  int          fe_starts[$];
  bit          mon_en = 1'b0;
  exp_t        mon_e;
  logic [7:0]  prev_an = 8'hFF;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s @%0t got %h exp %h", nm, $time, got, expv);
    end
  endtask

  // synchronized switch level seen in cycle c is the raw level from two cycles earlier
  function automatic logic raw_at(input bit right, input int c);
    if (c < 0) return 1'b0;
    return right ? hr[c] : hl[c];
  endfunction

  // debounced value for cycle c+1: flips only after four straight disagreeing cycles
  function automatic logic next_db(input bit right, input int c, input logic cur);
    if (c < DC - 1) return cur;
    for (int j = c - DC + 1; j <= c; j++)
      if (raw_at(right, j - 2) == cur) return cur;
    return ~cur;
  endfunction

  task automatic step(input bit wait_edge);
    int k, f, sc, pos, slot;
    logic [1:0]  m;
    logic [3:0]  nib;
    logic [15:0] src;
    exp_t e;
    if (wait_edge) @(negedge clk);
    sw_left = cur_l; sw_right = cur_r;
    digits_A = cur_a; digits_B = cur_b; digits_C = cur_c; digits_D = cur_d;
    hl.push_back(cur_l); hr.push_back(cur_r);
    ha.push_back(cur_a); hb.push_back(cur_b); hc.push_back(cur_c); hd.push_back(cur_d);
    k = hl.size() - 1;
    if (k == 0) begin
      dbl.push_back(1'b0); dbr.push_back(1'b0);
    end else begin
      dbl.push_back(next_db(1'b0, k - 1, dbl[k-1]));
      dbr.push_back(next_db(1'b1, k - 1, dbr[k-1]));
    end
    f    = k / FRAME;
    sc   = (f == 0) ? 0 : FRAME * f - 1;
    pos  = k % FRAME;
    slot = pos / SD;
    m    = dbr[sc] ? 2'd2 : (dbl[sc] ? 2'd1 : 2'd0);
    if (slot < 4) begin
      src = (m == 2'd1) ? hc[sc] : ((m == 2'd2) ? hd[sc] : ha[sc]);
      nib = src[slot*4 +: 4];
    end else if (m == 2'd0) begin
      src = hb[sc];
      nib = src[(slot-4)*4 +: 4];
    end else begin
      nib = 4'hF;
    end
    e.md = m;
    if (pos % SD < BC) begin
      e.an = 8'hFF; e.seg = 7'h7F;
    end else begin
      e.seg = glyph_tab[nib];
      e.an  = (nib == 4'hF) ? 8'hFF : ~(8'd1 << slot);
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    hl.delete(); hr.delete(); dbl.delete(); dbr.delete();
    ha.delete(); hb.delete(); hc.delete(); hd.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    mon_en = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  always @(negedge clk) begin
    #2;
    tick++;
    if (mon_en && rst_n) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("anodes", anodes, mon_e.an);
        chk("segments", segments, mon_e.seg);
        chk("mode", mode, mon_e.md);
      end
      if (anodes == 8'hFE && prev_an == 8'hFF) fe_starts.push_back(tick);
      prev_an = anodes;
    end
  end

  initial begin
    // reset state
    #12;
    chk("rst_anodes", anodes, 8'hFF);
    chk("rst_segments", segments, 7'h7F);
    chk("rst_mode", mode, 2'd0);

    // power-up frame, digits_A change during slot 2, 3-cycle sw_left glitch
    cur_a = 16'h1234; cur_b = 16'h5678; cur_c = 16'hABCD; cur_d = 16'hF0F0;
    do_reset();
    for (int i = 1; i < 3 * FRAME; i++) begin
      if (i == 20) cur_a = 16'h9999;
      cur_l = (i >= 70 && i < 73);
      step(1'b1);
    end
    #3 chk("glitch_mode", mode, 2'd0);

    // sw_left held from mid-slot 3
    cur_l = 1'b0; cur_a = 16'h1234; cur_c = 16'h00A9;
    do_reset();
    for (int i = 1; i < 3 * FRAME + 10; i++) begin
      if (i == 28) cur_l = 1'b1;
      step(1'b1);
    end
    #3 chk("mode_c", mode, 2'd1);

    // both switches held: priority and frame period across the mode change
    cur_l = 1'b1; cur_r = 1'b1; cur_d = 16'h4321;
    fe_starts.delete();
    do_reset();
    run(4 * FRAME);
    #3 chk("mode_d", mode, 2'd2);
    chk("period_samples", fe_starts.size() >= 3, 1);
    for (int i = 1; i < fe_starts.size(); i++)
      chk("frame_period", fe_starts[i] - fe_starts[i-1], FRAME);

    // randomized digits and switch activity
    cur_l = 1'b0; cur_r = 1'b0;
    cur_a = 16'($urandom); cur_b = 16'($urandom); cur_c = 16'($urandom); cur_d = 16'($urandom);
    do_reset();
    for (int i = 1; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: cur_a = 16'($urandom);
          1: cur_b = 16'($urandom);
          2: cur_c = 16'($urandom);
          default: cur_d = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 7) == 0) cur_l = ~cur_l;
      if ($urandom_range(0, 9) == 0) cur_r = ~cur_r;
      step(1'b1);
    end

    // asynchronous reset during ON of slot 5
    cur_l = 1'b0; cur_r = 1'b0; cur_a = 16'h1234; cur_b = 16'h5678;
    do_reset();
    run(44);
    @(posedge clk); #1;
    chk("pre_rst_slot5", anodes, 8'hDF);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rst_anodes", anodes, 8'hFF);
    chk("async_rst_segments", segments, 7'h7F);
    chk("async_rst_mode", mode, 2'd0);
    do_reset();
    run(FRAME + 8);

    repeat (2) @(negedge clk);
    #3 chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 16384, giving the clock cycles per digit slot.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 1024, giving the cycles of inter-digit blanking at the start of each slot (1 to SCAN_DIV-1).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the stable cycles required to accept a switch change.
REQ-004 clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 sw_left  input  1  asynchronous mode switch.
REQ-007 sw_right  input  1  asynchronous mode switch.
REQ-008 digits_A, digits_B, digits_C, digits_D  input  16 each  four 4-bit nibbles, [3:0] rightmost.
REQ-009 segments  output  7  registered cathodes, active-low, bit order gfedcba.
REQ-010 anodes  output  8  registered anodes, active-low, bit 0 rightmost.
REQ-011 mode  output  2  currently applied display mode.

Function
REQ-012 Each switch SHALL pass a 2-flop synchronizer and then a debouncer; the debounced value SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles, and any reversion SHALL clear the count.
REQ-013 Requested mode SHALL be 2 if debounced sw_right=1, else 1 if debounced sw_left=1, else 0; mode 3 SHALL be unreachable.
REQ-014 The scan FSM SHALL have states BLANK and ON; each slot SHALL spend BLANK_CYCLES in BLANK, then SCAN_DIV-BLANK_CYCLES in ON, then advance the digit index 0..7 with wrap 7->0.
REQ-015 In BLANK, anodes SHALL be 8'hFF and segments 7'h7F.
REQ-016 In ON, anode bit [index] SHALL be 0 and all others 1, unless the selected nibble is 4'hF, in which case anodes SHALL stay 8'hFF.
REQ-017 Slot sources: mode 0: slots 0-3 from digits_A, slots 4-7 from digits_B; mode 1: slots 0-3 from digits_C, slots 4-7 forced 4'hF; mode 2: slots 0-3 from digits_D, slots 4-7 forced 4'hF.
REQ-018 Glyphs: nibbles 0-9 SHALL show decimal digits; 4'hA-4'hE SHALL show a dash (7'h3F); 4'hF SHALL show blank (7'h7F).
REQ-019 On the cycle the index wraps 7->0 (frame boundary), the block SHALL latch the requested mode into mode and snapshot all four digit inputs; within a frame only snapshotted values SHALL be displayed.
REQ-020 A mode request change mid-frame SHALL take effect only at the next frame boundary, with no partial-frame tearing.
REQ-021 Frame period SHALL be exactly 8*SCAN_DIV cycles, unaffected by mode changes or switch activity.
REQ-022 The first frame after reset SHALL start at slot 0 BLANK, with the snapshot and mode loaded on the first cycle after rst_n deasserts.

Reset
REQ-023 While rst_n=0: anodes 8'hFF, segments 7'h7F, mode 2'd0, index 0, state BLANK, cycle counter 0, synchronizers and debounced switches 0, debounce counters 0, snapshot 16'hFFFF per source.
REQ-024 Reset assertion mid-ON SHALL force anodes to 8'hFF asynchronously, without waiting for a clock edge.

Structure
REQ-025 Shared package display_pkg SHALL hold the mode enum (MODE_AB=0, MODE_C=1, MODE_D=2), the BLANK_NIBBLE constant 4'hF, and the glyph constants GLYPH_0..GLYPH_9, GLYPH_DASH and GLYPH_BLANK.
REQ-026 Sub-module switch_debouncer (synchronizer plus counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice; the scan FSM and glyph decoding SHALL stay in the top level.

Verification (SCAN_DIV=8, BLANK_CYCLES=2, DEBOUNCE_CYCLES=4)
REQ-027 Bench scenario, reset release with digits_A=16'h1234, digits_B=16'h5678 and switches low: anodes 8'hFF for 2 cycles, then anodes 8'hFE with segments 7'h19 for 6 cycles, and slot 7 shows anodes 8'h7F with segments 7'h12.
REQ-028 Bench scenario, sw_left high for 3 cycles only: mode stays 0 indefinitely.
REQ-029 Bench scenario, sw_left held high from mid-slot 3 with digits_C=16'h00A9: mode becomes 1 at the next index wrap; slot 0 shows 7'h10 (9), slot 1 shows 7'h3F (dash), and slots 4-7 keep anodes 8'hFF.
REQ-030 Bench scenario, digits_A changed from 16'h1234 to 16'h9999 during slot 2: slots 2-3 still show 2 and 1, and slot 0 of the next frame shows 9.
REQ-031 Bench scenario, sw_left and sw_right both held high: mode becomes 2 at the frame boundary; the frame period measures 64 cycles before and after the change.
REQ-032 Bench scenario, rst_n pulsed low during ON of slot 5: anodes 8'hFF within the same cycle, and scanning restarts at slot 0 BLANK with mode 0.
